// File: rtl/strip_trig_pkg.sv
// -----------------------------------------------------------------------------
// strip_trig_pkg
// Shared definitions for the strip trigger scheduler: field widths, the packed
// request entry, the scheduler FSM state encoding and the default terminal value
// of the optional BCID stamp counter.
// The stamp counter is enabled by defining STRIP_TRIG_SCHED_BCID_STAMP_EN.
// -----------------------------------------------------------------------------
package strip_trig_pkg;

    localparam int BCID_W  = 12;
    localparam int PHI_W   = 5;
    localparam int BAND_W  = 8;
    localparam int ENTRY_W = BCID_W + PHI_W + BAND_W;   // 25

    localparam int BCID_MAX_DEFAULT = 3563;

    // One queued trigger request, MSB first: {bcid, phi_id, bandid}
    typedef struct packed {
        logic [BCID_W-1:0] bcid;
        logic [PHI_W-1:0]  phi_id;
        logic [BAND_W-1:0] bandid;
    } trig_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_WAIT_BUSY  = 2'd2,
        ST_WAIT_READY = 2'd3
    } sched_state_t;

endpackage

// File: rtl/strip_trig_fifo.sv
// -----------------------------------------------------------------------------
// strip_trig_fifo
// Small synchronous FIFO with registered pointers and occupancy level.
// The head entry is presented show-ahead (array read by the registered read
// pointer) so the consumer can capture it on the same edge that pops it.
// Pushes while full and pops while empty are ignored.
//
// Ports:
//   clk      in   clock
//   srst     in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write request
//   i_data   in   WIDTH-bit write data
//   i_pop    in   read request (advances past the head entry)
//   o_data   out  head entry
//   o_full   out  level == DEPTH
//   o_empty  out  level == 0
//   o_level  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module strip_trig_fifo #(
    parameter int DEPTH = 8,      // power of two, >= 2
    parameter int WIDTH = 25
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Storage carries no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/strip_trigger_scheduler.sv
// -----------------------------------------------------------------------------
// strip_trigger_scheduler
// Queues trigger requests and issues them one at a time to strip_trigger_gen,
// holding load for LOAD_CYCLES and then waiting for the generator's ready to
// go low (busy) and high again before issuing the next one. Each wait state is
// bounded by BUSY_TIMEOUT cycles; a timed-out request is dropped.
//
// Optional feature: define STRIP_TRIG_SCHED_BCID_STAMP_EN to stamp each request
// with an internal free-running BCID counter (wraps at BCID_MAX, cleared by
// bc_reset) instead of using trig_bcid_in.
//
// Ports:
//   clk_slow              in   sole clock
//   reset                 in   synchronous active-high reset
//   trig_valid            in   request strobe
//   trig_bcid_in[11:0]    in   request BCID (ignored when stamping)
//   trig_phi_id[4:0]      in   request phi id
//   trig_bandid[7:0]      in   request band id
//   trig_accept           out  FIFO not full
//   bc_reset              in   clears stamp counter (stamp build only)
//   gen_ready             in   generator ready, asynchronous
//   load                  out  generator load_input
//   trigger_content_BCID  out  generator BCID
//   phi_id                out  generator phi id
//   bandid                out  generator band id
//   busy                  out  FSM not idle
//   fifo_level            out  queue occupancy
//   overflow_cnt[7:0]     out  dropped requests, saturating
//   timeout_cnt[7:0]      out  wait-state timeouts, saturating
// -----------------------------------------------------------------------------
module strip_trigger_scheduler
    import strip_trig_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int LOAD_CYCLES  = 4,
    parameter int BUSY_TIMEOUT = 64,
    parameter int BCID_MAX     = BCID_MAX_DEFAULT
) (
    input  logic                          clk_slow,
    input  logic                          reset,
    input  logic                          trig_valid,
    input  logic [11:0]                   trig_bcid_in,
    input  logic [4:0]                    trig_phi_id,
    input  logic [7:0]                    trig_bandid,
    output logic                          trig_accept,
    input  logic                          bc_reset,
    input  logic                          gen_ready,
    output logic                          load,
    output logic [11:0]                   trigger_content_BCID,
    output logic [4:0]                    phi_id,
    output logic [7:0]                    bandid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt,
    output logic [7:0]                    timeout_cnt
);

    localparam int CNT_MAX = (LOAD_CYCLES > BUSY_TIMEOUT) ? LOAD_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // ---------------- ready synchroniser ----------------
    logic [1:0] r_rdy_sync;
    logic       w_rdy_s;

    always_ff @(posedge clk_slow) begin
        if (reset) r_rdy_sync <= 2'b00;
        else       r_rdy_sync <= {r_rdy_sync[0], gen_ready};
    end
    assign w_rdy_s = r_rdy_sync[1];

    // ---------------- request BCID source ----------------
    logic [BCID_W-1:0] w_push_bcid;

`ifdef STRIP_TRIG_SCHED_BCID_STAMP_EN
    logic [BCID_W-1:0] r_bcid_ctr;
    logic [BCID_W-1:0] w_unused_bcid_in;

    always_ff @(posedge clk_slow) begin
        if (reset || bc_reset)                  r_bcid_ctr <= '0;
        else if (r_bcid_ctr == BCID_W'(BCID_MAX)) r_bcid_ctr <= '0;
        else                                    r_bcid_ctr <= r_bcid_ctr + 1'b1;
    end
    assign w_push_bcid      = r_bcid_ctr;
    assign w_unused_bcid_in = trig_bcid_in;
`else
    logic [BCID_W:0] w_unused_cfg;
    assign w_push_bcid  = trig_bcid_in;
    assign w_unused_cfg = {bc_reset, BCID_W'(BCID_MAX)};
`endif

    // ---------------- request FIFO ----------------
    trig_entry_t        w_push_entry;
    trig_entry_t        w_head_entry;
    logic [ENTRY_W-1:0] w_head_bits;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    assign w_push_entry = '{bcid: w_push_bcid, phi_id: trig_phi_id, bandid: trig_bandid};
    assign w_head_entry = trig_entry_t'(w_head_bits);

    strip_trig_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk_slow),
        .srst    (reset),
        .i_push  (trig_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign trig_accept = ~w_full;

    // ---------------- scheduler FSM ----------------
    sched_state_t     r_state,     w_state_next;
    logic [CNT_W-1:0] r_cnt,       w_cnt_next;
    logic             r_seen_low,  w_seen_low_next;
    logic             r_load,      w_load_next;
    logic             w_timeout;

    always_ff @(posedge clk_slow) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_seen_low <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_seen_low <= w_seen_low_next;
            r_load     <= w_load_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_seen_low_next = r_seen_low;
        w_load_next     = r_load;
        w_pop           = 1'b0;
        w_timeout       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (~w_empty & w_rdy_s) begin
                    w_pop           = 1'b1;
                    w_load_next     = 1'b1;
                    w_seen_low_next = 1'b0;
                    w_cnt_next      = '0;
                    w_state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (~w_rdy_s) w_seen_low_next = 1'b1;
                if (r_cnt == CNT_W'(LOAD_CYCLES - 1)) begin
                    w_load_next  = 1'b0;
                    w_cnt_next   = '0;
                    // A busy dip already seen during load means the generator
                    // took the trigger; only its return to ready remains.
                    w_state_next = (r_seen_low | ~w_rdy_s) ? ST_WAIT_READY : ST_WAIT_BUSY;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                if (~w_rdy_s) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_WAIT_READY;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (w_rdy_s) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign load = r_load;
    assign busy = (r_state != ST_IDLE);

    // Data outputs are captured only on a pop and then held
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            trigger_content_BCID <= '0;
            phi_id               <= '0;
            bandid               <= '0;
        end else if (w_pop) begin
            trigger_content_BCID <= w_head_entry.bcid;
            phi_id               <= w_head_entry.phi_id;
            bandid               <= w_head_entry.bandid;
        end
    end

    // ---------------- saturating event counters ----------------
    always_ff @(posedge clk_slow) begin
        if (reset) begin
            overflow_cnt <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (trig_valid && w_full && (overflow_cnt != 8'hFF))
                overflow_cnt <= overflow_cnt + 1'b1;
            if (w_timeout && (timeout_cnt != 8'hFF))
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_strip_trigger_scheduler.sv
`timescale 1ns/1ps
module tb_strip_trigger_scheduler;

    localparam int LOAD_CYCLES = 4;

    logic        clk_slow = 1'b0;
    logic        reset = 1'b1;
    logic        trig_valid = 1'b0;
    logic [11:0] trig_bcid_in = '0;
    logic [4:0]  trig_phi_id = '0;
    logic [7:0]  trig_bandid = '0;
    logic        trig_accept;
    logic        bc_reset = 1'b0;
    logic        gen_ready = 1'b0;
    logic        load;
    logic [11:0] trigger_content_BCID;
    logic [4:0]  phi_id;
    logic [7:0]  bandid;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;
    logic [7:0]  timeout_cnt;

    always #5 clk_slow = ~clk_slow;

    strip_trigger_scheduler dut (
        .clk_slow             (clk_slow),
        .reset                (reset),
        .trig_valid           (trig_valid),
        .trig_bcid_in         (trig_bcid_in),
        .trig_phi_id          (trig_phi_id),
        .trig_bandid          (trig_bandid),
        .trig_accept          (trig_accept),
        .bc_reset             (bc_reset),
        .gen_ready            (gen_ready),
        .load                 (load),
        .trigger_content_BCID (trigger_content_BCID),
        .phi_id               (phi_id),
        .bandid               (bandid),
        .busy                 (busy),
        .fifo_level           (fifo_level),
        .overflow_cnt         (overflow_cnt),
        .timeout_cnt          (timeout_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [24:0] sb[$];          // expected {bcid, phi, band} in issue order
    int          rdy_mode = 1;   // 0: ready low, 1: ready high, 2: generator model
    bit          abort_pulse = 1'b0;
    int          n_loads = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_slow);
        @(negedge clk_slow);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

`ifdef STRIP_TRIG_SCHED_BCID_STAMP_EN
    // Reference BCID counter: value the DUT will stamp at the next edge
    logic [11:0] m_bcid = '0;
    always @(posedge clk_slow) begin
        if (reset || bc_reset)      m_bcid <= '0;
        else if (m_bcid == 12'd3563) m_bcid <= '0;
        else                        m_bcid <= m_bcid + 12'd1;
    end
`endif

    task automatic push_raw(input logic [11:0] b, input logic [4:0] p, input logic [7:0] d,
                            input bit expect_it, input logic [11:0] exp_b);
        trig_valid   = 1'b1;
        trig_bcid_in = b;
        trig_phi_id  = p;
        trig_bandid  = d;
        if (expect_it) sb.push_back({exp_b, p, d});
        $display("push bcid=0x%03h phi=%0d band=0x%02h expected=%0d", b, p, d, expect_it);
        step();
        trig_valid = 1'b0;
    endtask

    task automatic push(input logic [11:0] b, input logic [4:0] p, input logic [7:0] d, input bit expect_it);
`ifdef STRIP_TRIG_SCHED_BCID_STAMP_EN
        push_raw(b, p, d, expect_it, m_bcid);
`else
        push_raw(b, p, d, expect_it, b);
`endif
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int k = 0;
        while ((busy || fifo_level != 0 || sb.size() != 0) && k < max_cyc) begin
            step();
            k++;
        end
        check(name, (k < max_cyc), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          last_rise = -1000;
    int          hi_len = 0;
    logic        prev_load = 1'b0;
    logic [24:0] exp_e;

    always @(negedge clk_slow) begin
        cyc++;
        if (load && !prev_load) begin
            n_loads++;
            check("sb_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_e = sb.pop_front();
                $display("load bcid=0x%03h phi=%0d band=0x%02h want=0x%07h",
                         trigger_content_BCID, phi_id, bandid, exp_e);
                check("load_data", {trigger_content_BCID, phi_id, bandid}, exp_e);
            end
            check("load_spacing", ((cyc - last_rise) >= LOAD_CYCLES + 1), 1);
            last_rise = cyc;
            hi_len = 1;
        end else if (load) begin
            hi_len++;
        end else if (prev_load && !abort_pulse) begin
            check("load_width", hi_len, LOAD_CYCLES);
        end
        prev_load = load;
    end

    // ---------------- ready driver / generator model ----------------
    int   m_cnt = 0;
    int   hi_run = 0;
    logic m_prev_load = 1'b0;

    always @(negedge clk_slow) begin
        case (rdy_mode)
            0: begin gen_ready = 1'b0; m_cnt = 0; end
            1: begin gen_ready = 1'b1; m_cnt = 0; end
            default: begin
                if (load && !m_prev_load) begin
                    // Ready must have been back for the synchroniser plus the
                    // IDLE decision before a new load may appear
                    check("ready_before_load", (hi_run >= 3), 1);
                    m_cnt = 1;
                end else if (m_cnt > 0) begin
                    m_cnt++;
                end
                if (m_cnt == 12) m_cnt = 0;
                gen_ready = (m_cnt >= 2 && m_cnt <= 11) ? 1'b0 : 1'b1;
            end
        endcase
        hi_run = gen_ready ? hi_run + 1 : 0;
        m_prev_load = load;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rdy_mode = 1;
        @(negedge clk_slow);
        steps(3);
        // reset state
        check("rst_load", load, 0);
        check("rst_bcid", trigger_content_BCID, 0);
        check("rst_phi", phi_id, 0);
        check("rst_band", bandid, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_to", timeout_cnt, 0);
        check("rst_accept", trig_accept, 1);
        reset = 1'b0;
        steps(4);

        // latency, then timeout with ready stuck high
        push(12'h123, 5'd5, 8'h2A, 1);                 // edge N
        check("lat_no_passthru", load, 0);
        check("lat_level", fifo_level, 1);
        step();                                        // N+1
        check("lat_load", load, 1);
        push(12'h456, 5'd17, 8'hC3, 1);                // N+2
        steps(66);                                     // N+68
        check("to_not_yet", timeout_cnt, 0);
        check("to_busy", busy, 1);
        step();                                        // N+69
        check("to_cnt1", timeout_cnt, 1);
        check("to_idle", busy, 0);
        check("to_level", fifo_level, 1);
        step();                                        // N+70
        check("to_next_load", load, 1);
        check("to_next_level", fifo_level, 0);
        wait_idle(200, "to_drain");
        check("to_cnt2", timeout_cnt, 2);

        // generator handshake model, three requests in order
        rdy_mode = 2;
        step();
        base = n_loads;
        push(12'h001, 5'd1, 8'h11, 1);
        push(12'h002, 5'd2, 8'h22, 1);
        push(12'h003, 5'd3, 8'h33, 1);
        wait_idle(300, "model_drain");
        check("model_loads", n_loads - base, 3);
        check("model_no_timeout", timeout_cnt, 2);

        // overflow with ready held low
        rdy_mode = 0;
        steps(4);
        for (int i = 0; i < 10; i++)
            push(12'(12'h200 + i), 5'(i), 8'(8'hA0 + i), (i < 8));
        check("ovf_level", fifo_level, 8);
        check("ovf_cnt", overflow_cnt, 2);
        check("ovf_accept", trig_accept, 0);
        rdy_mode = 2;
        wait_idle(600, "ovf_drain");

`ifdef STRIP_TRIG_SCHED_BCID_STAMP_EN
        // bc_reset sampled at edge E; counter reads k after edge E+k
        bc_reset = 1'b1;
        step();
        bc_reset = 1'b0;
        steps(3563);
        push_raw(12'hFFF, 5'd9, 8'h55, 1, 12'd3563);
        push_raw(12'hFFF, 5'd10, 8'h66, 1, 12'd0);
        wait_idle(200, "stamp_drain");
`endif

        // reset during LOAD, then first load after reset
        rdy_mode = 1;
        steps(4);
        push(12'h0AB, 5'd11, 8'h77, 1);
        push(12'h0CD, 5'd12, 8'h88, 1);
        step();
        check("mid_pre_load", load, 1);
        reset = 1'b1;
        abort_pulse = 1'b1;
        sb.delete();
        step();
        check("mid_load", load, 0);
        check("mid_level", fifo_level, 0);
        check("mid_ovf", overflow_cnt, 0);
        check("mid_to", timeout_cnt, 0);
        check("mid_busy", busy, 0);
        check("mid_accept", trig_accept, 1);
        reset = 1'b0;
        push(12'h3EF, 5'd31, 8'hFE, 1);                // R1
        check("post_rst_r1", load, 0);
        step();                                        // R2
        check("post_rst_r2", load, 0);
        step();                                        // R3
        check("post_rst_r3", load, 1);
        abort_pulse = 1'b0;
        wait_idle(200, "post_rst_drain");

        check("sb_empty_end", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/strip_trigger_scheduler.md
# strip_trigger_scheduler

Buffers trigger requests and issues them one at a time to `strip_trigger_gen`, which accepts only one trigger per `ready` window. Sits directly upstream of the generator in the `clk_slow` domain. Drives the generator's `load_input`, `trigger_content_BCID_input`, `phi_id_input` and `bandid_input`. Consumes its 320 MHz-domain `ready` through an internal synchroniser.

## Interface
- `FIFO_DEPTH`, 8: request queue depth; must be a power of two, ≥2.
- `LOAD_CYCLES`, 4: `clk_slow` cycles `load` is held high per trigger; ≥2.
- `BUSY_TIMEOUT`, 64: max `clk_slow` cycles spent in each wait state.
- `BCID_MAX`, 3563: terminal value of the internal BCID counter.

- `clk_slow`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `trig_valid`  in  1  request strobe, one request per cycle.
- `trig_bcid_in`  in  12  request BCID; ignored when the stamp macro is defined.
- `trig_phi_id`  in  5  request phi id.
- `trig_bandid`  in  8  request band id.
- `trig_accept`  out  1  high when the FIFO is not full (combinational from level).
- `bc_reset`  in  1  zeroes the BCID counter; used only with the stamp macro.
- `gen_ready`  in  1  `ready` from `strip_trigger_gen`; asynchronous to this block.
- `load`  out  1  to generator `load_input`.
- `trigger_content_BCID`  out  12  to generator.
- `phi_id`  out  5  to generator.
- `bandid`  out  8  to generator.
- `busy`  out  1  high when the FSM is not in IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow_cnt`  out  8  dropped requests; saturates at 255.
- `timeout_cnt`  out  8  wait-state timeouts; saturates at 255.

## Operation
- `gen_ready` passes through a two-flop synchroniser that resets to 0. The output of that synchroniser is `rdy_s`.
- **Push:** a request is pushed when `trig_valid & ~full`. The stored entry is {bcid, phi_id, bandid}, 25 bits.
- **Overflow:** `trig_valid & full` drops the request and increments `overflow_cnt`. A pop in the same cycle does not rescue the request.
- **FSM states:** IDLE, LOAD, WAIT_BUSY, WAIT_READY.
- **IDLE:** when `~empty & rdy_s`:
  - pop the head entry;
  - register its fields onto the data outputs;
  - set `load`=1, clear `seen_low`, and go to LOAD.
- **LOAD:** hold `load`=1 for `LOAD_CYCLES` cycles.
  - `seen_low` is set if `rdy_s`=0 in any cycle.
  - On exit, `load`=0. Go to WAIT_READY if `seen_low` is set, otherwise go to WAIT_BUSY.
- **WAIT_BUSY:** go to WAIT_READY when `rdy_s`=0.
- **WAIT_READY:** go to IDLE when `rdy_s`=1.
- **Timeout:** in either wait state, reaching `BUSY_TIMEOUT` cycles increments `timeout_cnt` and returns the FSM to IDLE. The popped entry is discarded, not retried.
- **Data output stability:** the data outputs change only on a pop. They stay stable from the rise of `load` until the next pop.
- **Simultaneous push and pop:** both occur and the level is unchanged. Push and pop are legal together at any level except a push when full, which is dropped as above.

## Timing
- **Reset values:** every output is 0, except `trig_accept`=1.
  - FIFO empty, FSM in IDLE, counters 0, synchroniser 0.
- **Reset mid-operation:** `load` drops in the next cycle. Queued requests are lost.
- **Latency:** `trig_valid` sampled at edge N into an empty FIFO, with IDLE and `rdy_s`=1, gives `load`=1 and valid data after edge N+1. The same-edge pass-through path does not exist.
- **After reset:** the first `load` occurs no earlier than 3 edges after reset deasserts, because of the synchroniser.
- **Back-to-back triggers:** `load` rising edges are at least `LOAD_CYCLES`+1 cycles apart, plus the wait-state time.

## Configuration
- **`STRIP_TRIG_SCHED_BCID_STAMP_EN` defined:**
  - an internal 12-bit counter increments every cycle and wraps from `BCID_MAX` to 0;
  - `bc_reset` zeroes the counter synchronously, with priority over the increment;
  - the pushed bcid is the counter value at the push edge.
- **Not defined:** the counter is absent, and the pushed bcid is `trig_bcid_in`. `bc_reset` is unused.

## Structure
- **Shared package `strip_trig_pkg`:**
  - widths BCID_W=12, PHI_W=5, BAND_W=8;
  - ENTRY_W=25;
  - the FSM state enum;
  - the BCID_MAX default.
- **Sub-module `strip_trig_fifo`:** a synchronous FIFO with registered pointers and level, and full/empty flags.

## Test plan
- Reset, then hold `gen_ready`=1 and push bcid=0x123, phi=5, band=0x2A → `load` high for 4 cycles starting edge N+1, with outputs 0x123/5/0x2A.
- Push 3 requests; the model drops ready 1 cycle after `load` rises and raises it 10 cycles later → exactly 3 `load` pulses, in order, each issued only after ready returns.
- Push 10 requests with `gen_ready`=0 → `fifo_level`=8, `overflow_cnt`=2, `trig_accept`=0.
- Hold `gen_ready`=1 constantly after the first load → `timeout_cnt`=1 after 4+64 cycles, and the FSM returns to IDLE and serves the next entry.
- With the stamp macro: pulse `bc_reset`, then push at cycle 3563 and cycle 3564 → stamped bcids 3563 and 0.
- Assert `reset` during LOAD → `load`=0 after the next edge, `fifo_level`=0, all counters 0.
